// File: rtl/keyboard_interpreter_if.sv
// Scancode-in / command-out bundle between the PS/2 receiver, the interpreter and the game FSM.
// ps2_byte_valid is a one-cycle strobe with no ready: each byte is consumed on the strobe cycle,
// ps2_byte is a don't-care whenever ps2_byte_valid is low, and the source can never be stalled.
interface keyboard_interpreter_if;
    logic [7:0] ps2_byte;
    logic       ps2_byte_valid;
    logic       move_up;
    logic       move_down;
    logic       move_left;
    logic       move_right;
    logic       enter;
    logic       escape;
    logic [5:0] held;
    logic       prefix_timeout;
    logic [1:0] state_dbg;

    modport master (
        output ps2_byte, ps2_byte_valid,
        input  move_up, move_down, move_left, move_right, enter, escape,
        input  held, prefix_timeout, state_dbg
    );

    modport slave (
        input  ps2_byte, ps2_byte_valid,
        output move_up, move_down, move_left, move_right, enter, escape,
        output held, prefix_timeout, state_dbg
    );
endinterface

// File: rtl/keyboard_interpreter.sv
// Turns PS/2 set-2 scancodes into one-cycle game command pulses, tracking E0/F0 prefixes,
// held keys, typematic repeat suppression and a timeout that drops stale prefixes.
module keyboard_interpreter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 20,
    parameter bit          ACCEPT_KEYPAD  = 1'b1,
    parameter bit          REPEAT_EN      = 1'b0
) (
    input logic                  clk,
    input logic                  resetn,
    keyboard_interpreter_if.slave kb
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]       held_q;
    logic [5:0]       pulse_q;
    logic             timeout_q;

    logic             is_ext;
    logic             is_brk;
    logic [5:0]       key_oh_d;
    logic [5:0]       pulse_d;

    assign is_ext = (state_q == EXT) || (state_q == EXT_BRK);
    assign is_brk = (state_q == BRK) || (state_q == EXT_BRK);

    // One-hot command for the current byte: bit0 up, 1 down, 2 left, 3 right, 4 enter, 5 escape.
    always_comb begin
        key_oh_d = 6'b0;
        if (is_ext) begin
            case (kb.ps2_byte)
                8'h75:   key_oh_d = 6'b000001;
                8'h72:   key_oh_d = 6'b000010;
                8'h6B:   key_oh_d = 6'b000100;
                8'h74:   key_oh_d = 6'b001000;
                8'h5A:   key_oh_d = 6'b010000;
                default: key_oh_d = 6'b0;
            endcase
        end else begin
            case (kb.ps2_byte)
                8'h1D:   key_oh_d = 6'b000001;
                8'h1B:   key_oh_d = 6'b000010;
                8'h1C:   key_oh_d = 6'b000100;
                8'h23:   key_oh_d = 6'b001000;
                8'h5A:   key_oh_d = 6'b010000;
                8'h29:   key_oh_d = 6'b010000;
                8'h76:   key_oh_d = 6'b100000;
                8'h75:   key_oh_d = ACCEPT_KEYPAD ? 6'b000001 : 6'b0;
                8'h72:   key_oh_d = ACCEPT_KEYPAD ? 6'b000010 : 6'b0;
                8'h6B:   key_oh_d = ACCEPT_KEYPAD ? 6'b000100 : 6'b0;
                8'h74:   key_oh_d = ACCEPT_KEYPAD ? 6'b001000 : 6'b0;
                default: key_oh_d = 6'b0;
            endcase
        end
    end

    // Typematic repeats of an already-held key are swallowed unless repeats are enabled.
    assign pulse_d = REPEAT_EN ? key_oh_d : (key_oh_d & ~held_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            held_q    <= 6'b0;
            pulse_q   <= 6'b0;
            timeout_q <= 1'b0;
        end else begin
            pulse_q   <= 6'b0;
            timeout_q <= 1'b0;
            if (kb.ps2_byte_valid) begin
                cnt_q <= '0;
                case (kb.ps2_byte)
                    8'hE0: state_q <= EXT;
                    8'hF0: state_q <= is_ext ? EXT_BRK : BRK;
                    default: begin
                        state_q <= IDLE;
                        if (is_brk) begin
                            held_q <= held_q & ~key_oh_d;
                        end else begin
                            pulse_q <= pulse_d;
                            held_q  <= held_q | key_oh_d;
                        end
                    end
                endcase
            end else if (state_q != IDLE) begin
                if (cnt_q == CNT_LAST) begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    timeout_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign kb.move_up        = pulse_q[0];
    assign kb.move_down      = pulse_q[1];
    assign kb.move_left      = pulse_q[2];
    assign kb.move_right     = pulse_q[3];
    assign kb.enter          = pulse_q[4];
    assign kb.escape         = pulse_q[5];
    assign kb.held           = held_q;
    assign kb.prefix_timeout = timeout_q;
    assign kb.state_dbg      = state_q;

endmodule

// File: tb/tb_keyboard_interpreter.sv
// Bench for keyboard_interpreter: two parameterisations driven with the same byte stream,
// each compared cycle by cycle against a prefix/held-key reference model.
module tb_keyboard_interpreter;

  localparam int TMO = 16;

  logic clk;
  logic resetn;

  keyboard_interpreter_if kb_a ();
  keyboard_interpreter_if kb_b ();

  keyboard_interpreter #(
    .TIMEOUT_CYCLES(TMO), .CNT_W(5), .ACCEPT_KEYPAD(1'b1), .REPEAT_EN(1'b0)
  ) dut_a (
    .clk(clk), .resetn(resetn), .kb(kb_a.slave)
  );

  keyboard_interpreter #(
    .TIMEOUT_CYCLES(TMO), .CNT_W(5), .ACCEPT_KEYPAD(1'b0), .REPEAT_EN(1'b1)
  ) dut_b (
    .clk(clk), .resetn(resetn), .kb(kb_b.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
  endtask

  // reference model, one slot per DUT
  bit         cfg_keypad[2] = '{1'b1, 1'b0};
  bit         cfg_repeat[2] = '{1'b0, 1'b1};
  bit         m_ext[2];
  bit         m_brk[2];
  int         m_idle[2];
  logic [5:0] m_held[2];
  logic [5:0] exp_q[$];

  function automatic int key_of(input logic [7:0] b, input bit ext, input bit keypad);
    if (ext) begin
      case (b)
        8'h75: return 0;
        8'h72: return 1;
        8'h6B: return 2;
        8'h74: return 3;
        8'h5A: return 4;
        default: return -1;
      endcase
    end
    case (b)
      8'h1D: return 0;
      8'h1B: return 1;
      8'h1C: return 2;
      8'h23: return 3;
      8'h5A, 8'h29: return 4;
      8'h76: return 5;
      8'h75: return keypad ? 0 : -1;
      8'h72: return keypad ? 1 : -1;
      8'h6B: return keypad ? 2 : -1;
      8'h74: return keypad ? 3 : -1;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ext[d]  = 1'b0;
      m_brk[d]  = 1'b0;
      m_idle[d] = 0;
      m_held[d] = 6'b0;
    end
  endtask

  // Returns {timeout, pulse[5:0]} expected after this cycle's edge.
  function automatic logic [6:0] model_step(input int d, input bit v, input logic [7:0] b);
    logic [5:0] pulse;
    logic       tmo;
    int         k;
    pulse = 6'b0;
    tmo   = 1'b0;
    if (v) begin
      m_idle[d] = 0;
      if (b == 8'hE0) begin
        m_ext[d] = 1'b1;
        m_brk[d] = 1'b0;
      end else if (b == 8'hF0) begin
        m_brk[d] = 1'b1;
      end else begin
        k = key_of(b, m_ext[d], cfg_keypad[d]);
        if (k >= 0) begin
          if (m_brk[d]) m_held[d][k] = 1'b0;
          else begin
            if (!m_held[d][k] || cfg_repeat[d]) pulse[k] = 1'b1;
            m_held[d][k] = 1'b1;
          end
        end
        m_ext[d] = 1'b0;
        m_brk[d] = 1'b0;
      end
    end else if (m_ext[d] || m_brk[d]) begin
      m_idle[d]++;
      if (m_idle[d] == TMO) begin
        m_ext[d]  = 1'b0;
        m_brk[d]  = 1'b0;
        m_idle[d] = 0;
        tmo       = 1'b1;
      end
    end
    return {tmo, pulse};
  endfunction

  function automatic logic [5:0] pulses_a();
    return {kb_a.escape, kb_a.enter, kb_a.move_right, kb_a.move_left, kb_a.move_down, kb_a.move_up};
  endfunction

  function automatic logic [5:0] pulses_b();
    return {kb_b.escape, kb_b.enter, kb_b.move_right, kb_b.move_left, kb_b.move_down, kb_b.move_up};
  endfunction

  task automatic check_outputs(input string when);
    logic [5:0] e_pa, e_ha, e_pb, e_hb;
    logic [6:0] to_bits;
    e_pa = exp_q.pop_front();
    e_ha = exp_q.pop_front();
    e_pb = exp_q.pop_front();
    e_hb = exp_q.pop_front();
    to_bits = {1'b0, exp_q.pop_front()};
    check_eq({when, "_a_pulse"}, {2'b0, pulses_a()}, {2'b0, e_pa});
    check_eq({when, "_a_held"}, {2'b0, kb_a.held}, {2'b0, e_ha});
    check_eq({when, "_a_tmo"}, {7'b0, kb_a.prefix_timeout}, {7'b0, to_bits[0]});
    check_eq({when, "_b_pulse"}, {2'b0, pulses_b()}, {2'b0, e_pb});
    check_eq({when, "_b_held"}, {2'b0, kb_b.held}, {2'b0, e_hb});
    check_eq({when, "_b_tmo"}, {7'b0, kb_b.prefix_timeout}, {7'b0, to_bits[1]});
  endtask

  // driver: one clock cycle with an optional strobe
  task automatic step(input bit v, input logic [7:0] b);
    logic [6:0] ra, rb;
    kb_a.ps2_byte       = v ? b : 8'($urandom);
    kb_b.ps2_byte       = kb_a.ps2_byte;
    kb_a.ps2_byte_valid = v;
    kb_b.ps2_byte_valid = v;
    ra = model_step(0, v, b);
    rb = model_step(1, v, b);
    exp_q.push_back(ra[5:0]);
    exp_q.push_back(m_held[0]);
    exp_q.push_back(rb[5:0]);
    exp_q.push_back(m_held[1]);
    exp_q.push_back({4'b0, rb[6], ra[6]});
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1'b1, b);
    repeat (gap) step(1'b0, 8'h00);
  endtask

  task automatic check_all_zero(input string when);
    check_eq({when, "_a_pulse"}, {2'b0, pulses_a()}, 8'h00);
    check_eq({when, "_a_held"}, {2'b0, kb_a.held}, 8'h00);
    check_eq({when, "_a_tmo"}, {7'b0, kb_a.prefix_timeout}, 8'h00);
    check_eq({when, "_b_pulse"}, {2'b0, pulses_b()}, 8'h00);
    check_eq({when, "_b_held"}, {2'b0, kb_b.held}, 8'h00);
    check_eq({when, "_b_tmo"}, {7'b0, kb_b.prefix_timeout}, 8'h00);
  endtask

  logic [7:0] pool[16] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B,
                           8'h1C, 8'h23, 8'h5A, 8'h29, 8'h76, 8'hFA, 8'hAA, 8'hE0};

  initial begin
    resetn              = 1'b0;
    kb_a.ps2_byte       = 8'h00;
    kb_b.ps2_byte       = 8'h00;
    kb_a.ps2_byte_valid = 1'b0;
    kb_b.ps2_byte_valid = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    #8 resetn = 1'b1;

    // extended right press then release
    send(8'hE0, 0); send(8'h74, 2);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h74, 2);
    // typematic W, release, press again
    send(8'h1D, 1); send(8'h1D, 1); send(8'h1D, 1);
    send(8'hF0, 0); send(8'h1D, 1); send(8'h1D, 2);
    send(8'hF0, 0); send(8'h1D, 1);
    // keypad up, then release
    send(8'h75, 1); send(8'hF0, 0); send(8'h75, 1);
    // prefix timeout, then a following 74
    send(8'hE0, TMO + 2); send(8'h74, 1); send(8'hF0, 0); send(8'h74, 1);
    // strobe lands on the expiry cycle
    send(8'hE0, TMO - 1); send(8'h74, 2); send(8'hE0, 0); send(8'hF0, TMO - 1); send(8'h74, 2);
    // break prefix timeout
    send(8'hF0, TMO + 1);
    // enter / space / escape / unknowns
    send(8'h5A, 1); send(8'hF0, 0); send(8'h5A, 1); send(8'h29, 1); send(8'h76, 1);
    send(8'hFA, 1); send(8'hAA, 1);
    send(8'hE0, 0); send(8'h5A, 1); send(8'hE0, 0); send(8'hFA, 1);

    // asynchronous reset mid-cycle while W is held and a prefix is pending
    send(8'h1D, 1); send(8'hE0, 0);
    resetn = 1'b0;
    #2;
    check_all_zero("async_rst");
    model_reset();
    #2 resetn = 1'b1;
    send(8'h1D, 2);
    send(8'hF0, 0); send(8'h1D, 1);

    // randomized byte stream with occasional long gaps
    for (int i = 0; i < 600; i++) begin
      logic [7:0] b;
      int         gap;
      if ($urandom_range(0, 9) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 11) == 0) gap = $urandom_range(TMO - 2, TMO + 3);
      else gap = $urandom_range(0, 3);
      send(b, gap);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
